// File: rtl/uart_transmitter.sv
// Byte-buffered UART transmitter: small FIFO feeding an 8N1 serialiser, WAIT clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_transmitter #(
  parameter int WAIT  = 8,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       w_en,
  input  logic [7:0] w_data,
  output logic       w_ready,
  output logic       busy,
  output logic       uart_tx
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(WAIT);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              w_ready_q, w_ready_d;
  logic              push, pop, baud_end;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  always_comb begin
    push     = w_en && w_ready_q;
    pop      = 1'b0;
    baud_end = (baud_q == BAUD_W'(WAIT - 1));
    state_d  = state_q;
    baud_d   = baud_q + BAUD_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued bytes leave without an idle gap.
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase

`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
      parity_d = ^mem_q[rd_ptr_q];
`endif
    end

    // Line level is registered from the next state so each bit starts on the transition edge.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    w_ready_d = (count_d < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      w_ready_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_q + PTR_W'(push);
      rd_ptr_q  <= rd_ptr_q + PTR_W'(pop);
      count_q   <= count_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      w_ready_q <= w_ready_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign uart_tx = tx_q;
  assign w_ready = w_ready_q;
  assign busy    = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frame timing, back-to-back frames, FIFO full, reset abort, idle.
module tb_uart_transmitter;

  localparam int WAIT  = 8;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       w_en;
  logic [7:0] w_data;
  logic       w_ready;
  logic       busy;
  logic       uart_tx;

  int checks = 0;
  int errors = 0;

  logic exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  uart_transmitter #(.WAIT(WAIT), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .w_en    (w_en),
    .w_data  (w_data),
    .w_ready (w_ready),
    .busy    (busy),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit k of the result is the line level during bit period k of a frame.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  // Entered just after the edge that began cycle 'skip' of the frame; leaves just after the frame ends.
  task automatic check_frame(input logic [7:0] b, input int skip);
    logic [10:0] f;
    f = frame_bits(b);
    for (int i = skip; i < FB * WAIT; i++) begin
      chk($sformatf("tx_%02h_bit%0d_cyc%0d", b, i / WAIT, i), {31'd0, uart_tx}, {31'd0, f[i / WAIT]});
      chk($sformatf("busy_%02h_cyc%0d", b, i), {31'd0, busy}, 32'd1);
      tick();
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    w_en   = 1'b1;
    w_data = b;
    tick();
    w_en   = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    w_en   = 1'b0;
    w_data = 8'h00;
    tick();
    tick();
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_ready", {31'd0, w_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 500; i++) begin
      tick();
      chk($sformatf("idle_tx_%0d", i), {31'd0, uart_tx}, 32'd1);
      chk($sformatf("idle_busy_%0d", i), {31'd0, busy}, 32'd0);
    end

    // Single byte: line still high after the write edge, start bit from the next edge.
    write_byte(8'h0F);
    chk("lat_tx_at_write", {31'd0, uart_tx}, 32'd1);
    chk("lat_busy_at_write", {31'd0, busy}, 32'd1);
    tick();
    check_frame(8'h0F, 0);
    chk("end0f_tx", {31'd0, uart_tx}, 32'd1);
    chk("end0f_busy", {31'd0, busy}, 32'd0);

    // Back-to-back frames with no idle gap.
    w_en   = 1'b1;
    w_data = 8'h55;
    tick();
    w_data = 8'hAA;
    tick();
    w_en   = 1'b0;
    check_frame(8'h55, 0);
    check_frame(8'hAA, 0);
    chk("b2b_tx", {31'd0, uart_tx}, 32'd1);
    chk("b2b_busy", {31'd0, busy}, 32'd0);

    // Six writes into a depth-4 FIFO: first byte drains immediately, sixth is dropped.
    for (int i = 0; i < 6; i++) begin
      w_en   = 1'b1;
      w_data = 8'(i + 1);
      chk($sformatf("full_ready_%0d", i), {31'd0, w_ready}, {31'd0, exp_rdy[i]});
      tick();
    end
    w_en = 1'b0;
    chk("full_ready_after", {31'd0, w_ready}, 32'd0);
    check_frame(8'h01, 4);
    for (int b = 2; b <= 5; b++) check_frame(8'(b), 0);
    chk("full_end_tx", {31'd0, uart_tx}, 32'd1);
    chk("full_end_busy", {31'd0, busy}, 32'd0);
    chk("full_end_ready", {31'd0, w_ready}, 32'd1);

    // Reset during data bit 3 with two bytes still queued.
    w_en   = 1'b1;
    w_data = 8'hA0;
    tick();
    w_data = 8'hB1;
    tick();
    w_data = 8'hC2;
    tick();
    w_en   = 1'b0;
    repeat (33) tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    chk("pre_rst_ready", {31'd0, w_ready}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_tx", {31'd0, uart_tx}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, w_ready}, 32'd1);
    for (int i = 0; i < 300; i++) begin
      tick();
      chk($sformatf("post_abort_tx_%0d", i), {31'd0, uart_tx}, 32'd1);
      chk($sformatf("post_abort_busy_%0d", i), {31'd0, busy}, 32'd0);
    end

`ifdef UART_TX_PARITY_EN
    write_byte(8'h07);
    tick();
    check_frame(8'h07, 0);
    write_byte(8'h03);
    tick();
    check_frame(8'h03, 0);
    chk("par_end_busy", {31'd0, busy}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Byte-oriented UART transmitter; the transmit counterpart of the board's uart_rx receive path.
- Sits inside mother_board between the CPU's I/O write port and the uart_tx pin.
- Buffers bytes in a small FIFO and serialises each as 8N1: start bit low, 8 data bits LSB first, stop bit high, idle high.
- Each bit lasts exactly WAIT clock cycles, the same WAIT the receiver uses.

Parameters:
- WAIT, 8, clock cycles per UART bit; legal range >= 2.
- DEPTH, 4, FIFO entries; must be a power of 2, >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- w_en  input  1  write strobe; byte is accepted on a rising edge where w_en && w_ready
- w_data  input  8  byte to transmit
- w_ready  output  1  high when FIFO count < DEPTH; registered
- busy  output  1  high while a frame is in progress or the FIFO is non-empty
- uart_tx  output  1  serial line; registered, idle high

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high; it takes effect only on a rising edge of clk.
- Reset values: uart_tx=1, w_ready=1, busy=0, FIFO count=0, FSM=IDLE, bit/baud counters=0.
- Reset mid-frame: the frame is aborted and the FIFO flushed; uart_tx is 1 from the reset edge.
- FIFO:
  - Circular buffer with read/write pointers of log2(DEPTH) bits that wrap naturally.
  - Count has log2(DEPTH)+1 bits.
  - Push when w_en && w_ready. Write while full is ignored and the data is dropped, even if a pop occurs the same cycle.
  - Simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP (plus PARITY with the option below).
  - IDLE: uart_tx=1. If FIFO non-empty: pop into an 8-bit shift register, go to START; uart_tx=0 from that edge.
  - START: hold 0 for WAIT cycles, then DATA with bit index 0.
  - DATA: drive shift[0] for WAIT cycles, then shift right. After bit index 7 completes, go to STOP.
  - STOP: drive 1 for WAIT cycles. At the end of the stop bit, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..WAIT-1 within each bit and resets to 0 on every state change.
- Latency: byte written at edge N into an empty, idle block drives uart_tx low from edge N+1.
- Frame length: exactly 10*WAIT cycles.
- busy = (state != IDLE) || (count != 0).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for WAIT cycles. Frame = 11*WAIT cycles.
- Undefined: no PARITY state; frame is 8N1, 10*WAIT cycles.

Test Plan:
- WAIT=8, idle block. Write 0x0F at edge N -> uart_tx from edge N+1: 0,1,1,1,1,0,0,0,0,1, each held 8 cycles. Back to 1/idle at edge N+81; busy falls at the same edge.
- Write 0x55 then 0xAA on consecutive cycles -> two frames back to back, 160 cycles total. Stop bit of frame 1 is immediately followed by the start bit of frame 2; no extra idle cycle.
- DEPTH=4. Assert w_en for 6 consecutive cycles with bytes 0x01..0x06:
  - Bytes 0x01..0x05 accepted; w_ready low from the edge after the 5th accept; 0x06 dropped.
  - Line carries 0x01..0x05 in order over 5*80 cycles.
- Assert reset for 1 cycle during DATA bit 3 of a frame with 2 bytes queued -> uart_tx=1, busy=0, w_ready=1 from the reset edge. No further frames are sent.
- No writes for 500 cycles after reset -> uart_tx stays 1 and busy stays 0 throughout.
- With UART_TX_PARITY_EN, write 0x07 -> bit sequence 0,1,1,1,0,0,0,0,0,1(parity),1(stop), 88 cycles total. Write 0x03 -> parity bit 0.
